nonce_scheduler: RTL and testbench

NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

---
 rtl/nonce_scheduler.sv | 148 ++++++++++++++
 tb/tb_nonce_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_scheduler.sv
// Hands out nonce ranges to a pipelined hash core, blanks stale matches after a
// midstate change and queues golden nonces (tagged with the job id) for readout.
module nonce_scheduler #(
  parameter int unsigned MATCH_LATENCY = 261,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic         hash_clk,
  input  logic         reset,
  input  logic         work_valid,
  output logic         work_ready,
  input  logic [255:0] work_midstate,
  input  logic [95:0]  work_data,
  input  logic [3:0]   work_id,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic [255:0] core_midstate,
  output logic [95:0]  core_data,
  output logic [31:0]  core_nonce,
  input  logic         core_match,
  input  logic [31:0]  core_golden_nonce,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [31:0]  res_nonce,
  output logic [3:0]   res_id,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; work_valid/res_ready may depend on ready/valid, never the reverse.
  localparam int CW = (MATCH_LATENCY < 1) ? 1 : $clog2(MATCH_LATENCY + 1);
  localparam int AW = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAT      = CW'(MATCH_LATENCY);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [255:0]   core_midstate_q;
  logic [95:0]    core_data_q;
  logic [31:0]    core_nonce_q;
  logic [3:0]     job_id_q;
  logic [31:0]    job_start_q, job_end_q;
  logic [CW-1:0]  blank_cnt_q, drain_cnt_q;
  logic           done_q, overflow_q;
  logic [35:0]    fifo_q [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [AW:0]    count_q;

  logic load, at_end, drain_last, match_ok, fifo_full, fifo_empty, push, pop;

  assign load       = work_valid && work_ready;
  assign at_end     = (core_nonce_q == job_end_q);
  assign drain_last = (drain_cnt_q <= CW'(1));
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = !fifo_empty && res_ready;
  // Range test is done relative to start so wrapped ranges need no special case.
  assign match_ok   = core_match && (blank_cnt_q == '0) &&
                      (state_q == S_RUN || state_q == S_DRAIN) &&
                      ((core_golden_nonce - job_start_q) <= (job_end_q - job_start_q));
  assign push       = match_ok && (!fifo_full || pop);

  always_ff @(posedge hash_clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (load) state_d = S_RUN;
      S_RUN:   if (!load && at_end) state_d = S_DRAIN;
      S_DRAIN: if (drain_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    work_ready = (state_q != S_DRAIN);
    busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    dbg_state  = state_q;
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      core_midstate_q <= '0;
      core_data_q     <= '0;
      core_nonce_q    <= '0;
      job_id_q        <= '0;
      job_start_q     <= '0;
      job_end_q       <= '0;
      blank_cnt_q     <= '0;
      drain_cnt_q     <= '0;
      done_q          <= 1'b0;
    end else begin
      done_q <= (state_q == S_DRAIN) && drain_last;
      if (load) begin
        core_midstate_q <= work_midstate;
        core_data_q     <= work_data;
        core_nonce_q    <= nonce_start;
        job_id_q        <= work_id;
        job_start_q     <= nonce_start;
        job_end_q       <= nonce_end;
        blank_cnt_q     <= LAT;
      end else begin
        if (blank_cnt_q != '0) blank_cnt_q <= blank_cnt_q - CW'(1);
        if (state_q == S_RUN && !at_end) core_nonce_q <= core_nonce_q + 32'd1;
      end
      if (state_q == S_RUN && !load && at_end) drain_cnt_q <= LAT;
      else if (state_q == S_DRAIN && drain_cnt_q != '0) drain_cnt_q <= drain_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {job_id_q, core_golden_nonce};
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + (AW+1)'(1);
      else if (pop && !push) count_q <= count_q - (AW+1)'(1);
      if (match_ok && fifo_full && !pop) overflow_q <= 1'b1;
    end
  end

  assign core_midstate       = core_midstate_q;
  assign core_data           = core_data_q;
  assign core_nonce          = core_nonce_q;
  assign res_valid           = !fifo_empty;
  assign {res_id, res_nonce} = fifo_q[rd_ptr_q];
  assign done                = done_q;
  assign overflow            = overflow_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Directed bench for nonce_scheduler: range walk, wrap, blanking, reload,
// FIFO overflow and reset during DRAIN, all with hand-derived expectations.
module tb_nonce_scheduler;

  localparam logic [1:0] ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2;

  logic         hash_clk = 1'b0;
  logic         reset = 1'b1;
  logic         work_valid = 1'b0;
  logic         work_ready;
  logic [255:0] work_midstate = '0;
  logic [95:0]  work_data = '0;
  logic [3:0]   work_id = '0;
  logic [31:0]  nonce_start = '0, nonce_end = '0;
  logic [255:0] core_midstate;
  logic [95:0]  core_data;
  logic [31:0]  core_nonce;
  logic         core_match = 1'b0;
  logic [31:0]  core_golden_nonce = '0;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [31:0]  res_nonce;
  logic [3:0]   res_id;
  logic         busy, done, overflow;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int done_seen = 0;

  nonce_scheduler dut (
    .hash_clk(hash_clk), .reset(reset),
    .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_data(work_data), .work_id(work_id),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .core_midstate(core_midstate), .core_data(core_data), .core_nonce(core_nonce),
    .core_match(core_match), .core_golden_nonce(core_golden_nonce),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce), .res_id(res_id),
    .busy(busy), .done(done), .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 hash_clk = ~hash_clk;

  always @(posedge hash_clk) if (done) done_seen++;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge hash_clk);
      #1;
    end
  endtask

  task automatic load_work(input logic [3:0] id, input logic [31:0] s, input logic [31:0] e);
    work_valid    = 1'b1;
    work_id       = id;
    nonce_start   = s;
    nonce_end     = e;
    work_midstate = {8{s}};
    work_data     = {3{e}};
    tick();
    work_valid = 1'b0;
  endtask

  task automatic match_cycle(input logic [31:0] n);
    core_match        = 1'b1;
    core_golden_nonce = n;
    tick();
    core_match = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    n_vec++; if (work_ready !== 1'b1) begin n_err++; $display("FAIL reset_work_ready: got %b expected 1", work_ready); end
    n_vec++; if ({res_valid, busy, done, overflow} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b expected 0000", {res_valid, busy, done, overflow}); end
    n_vec++; if ({core_nonce, res_nonce, res_id} !== 68'h0) begin n_err++; $display("FAIL reset_values: got %h expected 0", {core_nonce, res_nonce, res_id}); end
    n_vec++; if ({core_midstate, core_data} !== 352'h0) begin n_err++; $display("FAIL reset_core: got nonzero expected 0"); end
  endtask

  task automatic test_range;
    int k;
    int d0;
    d0 = done_seen;
    load_work(4'd1, 32'h100, 32'h1FF);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL range_busy: got %b expected 1", busy); end
    n_vec++; if (core_midstate !== {8{32'h100}}) begin n_err++; $display("FAIL range_midstate: got %h expected replicated 100", core_midstate[31:0]); end
    for (int i = 0; i < 256; i++) begin
      n_vec++; if (core_nonce !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL range_nonce: got %h expected %h", core_nonce, 32'h100 + 32'(i)); end
      tick();
    end
    n_vec++; if (core_nonce !== 32'h1FF) begin n_err++; $display("FAIL range_hold: got %h expected 1ff", core_nonce); end
    n_vec++; if (work_ready !== 1'b0) begin n_err++; $display("FAIL range_drain_ready: got %b expected 0", work_ready); end
    k = 0;
    while (dbg_state == ST_DRAIN && k < 400) begin
      k++;
      tick();
    end
    n_vec++; if (k !== 261) begin n_err++; $display("FAIL range_drain_len: got %0d expected 261", k); end
    n_vec++; if (dbg_state !== ST_IDLE || done !== 1'b1) begin n_err++; $display("FAIL range_done: got state %0d done %b expected 0 1", dbg_state, done); end
    tick();
    n_vec++; if (done_seen - d0 !== 1) begin n_err++; $display("FAIL range_done_count: got %0d expected 1", done_seen - d0); end
  endtask

  task automatic test_wrap;
    logic [31:0] seq [4];
    seq = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    load_work(4'd5, 32'hFFFFFFFE, 32'h00000001);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (core_nonce !== seq[i]) begin n_err++; $display("FAIL wrap_nonce: got %h expected %h", core_nonce, seq[i]); end
      tick();
    end
    n_vec++; if (dbg_state !== ST_DRAIN) begin n_err++; $display("FAIL wrap_drain: got %0d expected %0d", dbg_state, ST_DRAIN); end
    tick(257);
    match_cycle(32'h0);
    match_cycle(32'h5);
    n_vec++; if ({res_valid, res_id, res_nonce} !== {1'b1, 4'd5, 32'h0}) begin n_err++; $display("FAIL wrap_result: got %b %h %h expected 1 5 0", res_valid, res_id, res_nonce); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL wrap_reject: got %b expected 0", res_valid); end
    n_vec++; if (dbg_state !== ST_DRAIN) begin n_err++; $display("FAIL wrap_late_drain: got %0d expected %0d", dbg_state, ST_DRAIN); end
    tick();
    n_vec++; if (dbg_state !== ST_IDLE || done !== 1'b1) begin n_err++; $display("FAIL wrap_exit: got state %0d done %b expected 0 1", dbg_state, done); end
  endtask

  task automatic test_blank;
    load_work(4'd9, 32'h1000, 32'h1FFF);
    tick(9);
    match_cycle(32'h1005);
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL blank_early: got %b expected 0", res_valid); end
    tick(250);
    match_cycle(32'h1000);
    match_cycle(32'h1001);
    n_vec++; if ({res_valid, res_id, res_nonce} !== {1'b1, 4'd9, 32'h1001}) begin n_err++; $display("FAIL blank_accept: got %b %h %h expected 1 9 1001", res_valid, res_id, res_nonce); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL blank_edge: got %b expected 0", res_valid); end
  endtask

  task automatic test_back_to_back;
    int d0;
    int k;
    d0 = done_seen;
    n_vec++; if (dbg_state !== ST_RUN || work_ready !== 1'b1) begin n_err++; $display("FAIL b2b_pre: got state %0d ready %b expected 1 1", dbg_state, work_ready); end
    load_work(4'd3, 32'h5000, 32'h5003);
    n_vec++; if (core_nonce !== 32'h5000) begin n_err++; $display("FAIL b2b_jump: got %h expected 5000", core_nonce); end
    match_cycle(32'h5001);
    n_vec++; if (core_nonce !== 32'h5001) begin n_err++; $display("FAIL b2b_step: got %h expected 5001", core_nonce); end
    tick(2);
    load_work(4'd4, 32'h6000, 32'h6000);
    n_vec++; if (dbg_state !== ST_RUN || core_nonce !== 32'h6000) begin n_err++; $display("FAIL b2b_end_load: got state %0d nonce %h expected 1 6000", dbg_state, core_nonce); end
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL b2b_stale: got %b expected 0", res_valid); end
    tick();
    n_vec++; if (dbg_state !== ST_DRAIN || core_nonce !== 32'h6000) begin n_err++; $display("FAIL b2b_single: got state %0d nonce %h expected 2 6000", dbg_state, core_nonce); end
    k = 0;
    while (dbg_state != ST_IDLE && k < 400) begin
      k++;
      tick();
    end
    tick();
    n_vec++; if (done_seen - d0 !== 1) begin n_err++; $display("FAIL b2b_done_count: got %0d expected 1", done_seen - d0); end
  endtask

  task automatic test_overflow;
    logic [31:0] exp_n [4];
    exp_n = '{32'd2, 32'd3, 32'd4, 32'd6};
    load_work(4'd7, 32'h0, 32'hFFFF);
    tick(261);
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b expected 0", overflow); end
      end
      match_cycle(32'(i));
    end
    n_vec++; if ({res_valid, overflow, res_id, res_nonce} !== {2'b11, 4'd7, 32'd1}) begin n_err++; $display("FAIL ovf_set: got %b %b %h %h expected 1 1 7 1", res_valid, overflow, res_id, res_nonce); end
    res_ready = 1'b1;
    match_cycle(32'd6);
    res_ready = 1'b0;
    n_vec++; if (overflow !== 1'b1 || res_nonce !== 32'd2) begin n_err++; $display("FAIL ovf_push_pop: got %b %h expected 1 2", overflow, res_nonce); end
    load_work(4'd8, 32'h10, 32'h20);
    n_vec++; if (res_id !== 4'd7 || res_nonce !== 32'd2) begin n_err++; $display("FAIL ovf_load_keep: got %h %h expected 7 2", res_id, res_nonce); end
    for (int j = 0; j < 4; j++) begin
      n_vec++; if (res_valid !== 1'b1 || res_nonce !== exp_n[j]) begin n_err++; $display("FAIL ovf_drain: got %b %h expected 1 %h", res_valid, res_nonce, exp_n[j]); end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
    end
    n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL ovf_empty: got %b expected 0", res_valid); end
  endtask

  task automatic test_reset_drain;
    int d0;
    int k;
    k = 0;
    while (dbg_state != ST_IDLE && k < 400) begin
      k++;
      tick();
    end
    n_vec++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rstd_wait_idle: got %0d expected 0", dbg_state); end
    load_work(4'd2, 32'h20, 32'h30);
    tick(261);
    match_cycle(32'h20);
    match_cycle(32'h25);
    n_vec++; if (dbg_state !== ST_DRAIN || res_valid !== 1'b1) begin n_err++; $display("FAIL rstd_pre: got state %0d valid %b expected 2 1", dbg_state, res_valid); end
    d0 = done_seen;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_vec++; if ({res_valid, busy, overflow} !== 3'b000 || dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rstd_clear: got %b state %0d expected 000 0", {res_valid, busy, overflow}, dbg_state); end
    n_vec++; if (work_ready !== 1'b1 || core_nonce !== 32'h0) begin n_err++; $display("FAIL rstd_ready: got %b %h expected 1 0", work_ready, core_nonce); end
    tick(300);
    n_vec++; if (done_seen !== d0) begin n_err++; $display("FAIL rstd_no_done: got %0d expected %0d", done_seen, d0); end
  endtask

  initial begin
    test_reset();
    test_range();
    test_wrap();
    test_blank();
    test_back_to_back();
    test_overflow();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
